spart_bus_arb: RTL and testbench
================================

# spart_bus_arb

- Round-robin arbiter sharing one SPART processor-side I/O bus (iocs/iorw/ioaddr/databus) between N independent requesters.
- Typical requesters: echo driver, baud-config loader, message transmitter.
- Each access runs as one bus cycle.
- Buffer accesses are held off until the SPART is ready: TX write waits for tbr, RX read waits for rda. A blocked requester never stalls a ready one.

## Interface
Parameters:
- N, default 2: number of requesters, minimum 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- req, input, N: per-requester access request; held high until ack.
- rw, input, N: per-requester direction; 1 = read, 0 = write.
- addr, input, 2*N: per-requester ioaddr; requester i uses bits [2i+1:2i].
- wdata, input, 8*N: per-requester write data.
- ack, output, N: one-cycle completion pulse to the granted requester.
- rdata, output, 8: read data; valid while ack is high.
- grant_id, output, $clog2(N): index of the last granted requester.
- iocs, output, 1: SPART chip select.
- iorw, output, 1: SPART direction.
- ioaddr, output, 2: SPART register address.
- databus, inout, 8: SPART data bus; driven only on write access cycles.
- rda, input, 1: SPART receive data available.
- tbr, input, 1: SPART transmit buffer ready.

## Operation
- Address map:
  - 00: TX buffer when rw=0, RX buffer when rw=1.
  - 01: status register (read).
  - 10: divisor low byte.
  - 11: divisor high byte.
- Eligibility, evaluated per requester each cycle in IDLE: eligible = req & ready.
  - ready = tbr for addr 00 with rw=0.
  - ready = rda for addr 00 with rw=1.
  - ready = 1 for all other addresses.
- States:
  - IDLE: pick the first eligible requester starting at ptr and wrapping modulo N. Latch its index, rw, addr and wdata; go to ACCESS. If none is eligible, stay in IDLE.
  - ACCESS (1 cycle):
    - Bus outputs: iocs=1, iorw=latched rw, ioaddr=latched addr.
    - Write: databus driven with latched wdata.
    - Read: databus hi-Z; databus is sampled into rdata at the end of the cycle.
    - Next state: ACK.
  - ACK (1 cycle): ack[grant] = 1; rdata holds. ptr = (grant+1) mod N, wrapping from N-1 to 0. Next state: IDLE.
- Fixed access period of 3 cycles; back-to-back grants are possible every 3 cycles.
- Requester contract: req is registered and drops at the clock edge ending the ack cycle. The next IDLE therefore sees it low. A request still high in IDLE is treated as a new request.
- Write data and addr are latched, so a requester changing wdata during ACCESS has no effect.
- rdata is updated only by read accesses; writes leave it unchanged.
- A requester whose ready stays low waits indefinitely. Other requesters keep being served round-robin, with no starvation among eligible requesters.
- Simultaneous events:
  - tbr/rda changing during ACCESS or ACK has no effect on the access in flight.
  - A new req arriving during ACCESS or ACK is considered at the next IDLE.

## Timing
- Reset values:
  - state: IDLE.
  - ptr: 0; grant_id: 0.
  - ack: 0; rdata: 0x00.
  - iocs: 0; iorw: 0; ioaddr: 00.
  - databus: hi-Z.
- Reset mid-access aborts the access immediately (asynchronous):
  - iocs and the databus drive drop in the same cycle.
  - No ack is issued; the requester must re-request.
- Latency from eligible req in IDLE at cycle t:
  - iocs high in cycle t+1.
  - ack high in cycle t+2.
- Outputs iocs, iorw, ioaddr, ack, rdata and grant_id are registered or decoded from registered state only; no combinational path from req to the bus.
- databus is driven in exactly the cycles where iocs=1 and iorw=0, and never in any other cycle.

## Structure
- Shared package spart_pkg:
  - ioaddr constants: ADDR_BUF, ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI.
  - State enum type {IDLE, ACCESS, ACK}.
- Sub-module rr_pick: purely combinational. Inputs: eligible vector and ptr. Outputs: found and index. Parameterised by N.

## Test plan
- Single write: N=2; req[0], rw=0, addr=11, wdata=0x27 at t0.
  - Required: iocs=1, ioaddr=11, databus=0x27 at t0+1; ack[0] at t0+2.
- TX gating: req[1] writes addr 00, wdata=0x41, with tbr=0 for 10 cycles, then tbr=1.
  - Required: no iocs while tbr=0; access one cycle after tbr rises is seen in IDLE; ack[1] one cycle after that.
- Head-of-line bypass: req[0] reads addr 00 with rda=0, and req[1] reads addr 01 with the SPART returning 0x03.
  - Required: requester 1 is served with rdata=0x03 and ack[1]; requester 0 keeps waiting.
- Round-robin fairness: both requesters continuously issue status reads.
  - Required: grant_id alternates 0,1,0,1 and an ack occurs every 3 cycles.
- Reset mid-access: assert rst during ACCESS of a write.
  - Required: iocs=0 and databus hi-Z within the same cycle; no ack; after release, state IDLE and ptr=0.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: register addresses, arbiter state type and the
// buffer-readiness rule used to gate requests.
package spart_pkg;

   localparam logic [1:0] ADDR_BUF    = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   // Only the data buffer is gated: TX writes need tbr, RX reads need rda.
   function automatic logic is_ready(input logic [1:0] a, input logic rd,
                                     input logic tbr, input logic rda);
      logic r;
      r = 1'b1;
      case (a)
         ADDR_BUF:                            r = rd ? rda : tbr;
         ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spart_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after
// ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Walk from the farthest candidate back to ptr so the closest one wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      sum   = '0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
         end
         idx = sum[IW-1:0];
         if (eligible[idx]) begin
            found = 1'b1;
            index = idx;
         end
      end
   end

endmodule

// File: rtl/spart_bus_arb.sv
// Round-robin arbiter sharing one SPART processor-side bus between N
// requesters; each grant runs IDLE -> ACCESS -> ACK (3 cycles).
module spart_bus_arb
   import spart_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         rw,
   input  logic [2*N-1:0]       addr,
   input  logic [8*N-1:0]       wdata,
   output logic [N-1:0]         ack,
   output logic [7:0]           rdata,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 iocs,
   output logic                 iorw,
   output logic [1:0]           ioaddr,
   inout  wire  [7:0]           databus,
   input  logic                 rda,
   input  logic                 tbr
);

   localparam int IW = $clog2(N);

   state_t        state_reg;
   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] grant_reg;
   logic          rw_reg;
   logic [7:0]    wdata_reg;
   logic [7:0]    rdata_reg;
   logic [N-1:0]  ack_reg;
   logic          iocs_reg;
   logic          iorw_reg;
   logic [1:0]    ioaddr_reg;
   logic          drive_reg;

   logic [N-1:0]  eligible;
   logic          pick_found;
   logic [IW-1:0] pick_index;
   logic          sel_rw;
   logic [1:0]    sel_addr;
   logic [7:0]    sel_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_elig
         assign eligible[gi] = req[gi] & is_ready(addr[2*gi +: 2], rw[gi], tbr, rda);
      end
   endgenerate

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .eligible (eligible),
      .ptr      (ptr_reg),
      .found    (pick_found),
      .index    (pick_index)
   );

   always_comb begin
      sel_rw    = 1'b0;
      sel_addr  = 2'b00;
      sel_wdata = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (pick_index == IW'(i)) begin
            sel_rw    = rw[i];
            sel_addr  = addr[2*i +: 2];
            sel_wdata = wdata[8*i +: 8];
         end
      end
   end

   // Asynchronous reset drops iocs and the bus drive at once, aborting any access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         grant_reg  <= '0;
         rw_reg     <= 1'b0;
         wdata_reg  <= 8'h00;
         rdata_reg  <= 8'h00;
         ack_reg    <= '0;
         iocs_reg   <= 1'b0;
         iorw_reg   <= 1'b0;
         ioaddr_reg <= 2'b00;
         drive_reg  <= 1'b0;
      end else begin
         ack_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (pick_found) begin
                  grant_reg  <= pick_index;
                  rw_reg     <= sel_rw;
                  wdata_reg  <= sel_wdata;
                  iocs_reg   <= 1'b1;
                  iorw_reg   <= sel_rw;
                  ioaddr_reg <= sel_addr;
                  drive_reg  <= ~sel_rw;
                  state_reg  <= ACCESS;
               end
            end
            ACCESS: begin
               if (rw_reg) begin
                  rdata_reg <= databus;
               end
               iocs_reg   <= 1'b0;
               iorw_reg   <= 1'b0;
               ioaddr_reg <= 2'b00;
               drive_reg  <= 1'b0;
               ack_reg    <= N'(1) << grant_reg;
               state_reg  <= ACK;
            end
            ACK: begin
               if (grant_reg == IW'(N - 1)) begin
                  ptr_reg <= '0;
               end else begin
                  ptr_reg <= grant_reg + 1'b1;
               end
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign databus  = drive_reg ? wdata_reg : 8'hzz;
   assign ack      = ack_reg;
   assign rdata    = rdata_reg;
   assign grant_id = grant_reg;
   assign iocs     = iocs_reg;
   assign iorw     = iorw_reg;
   assign ioaddr   = ioaddr_reg;

endmodule

// File: tb/tb_spart_bus_arb.sv
// Directed bench for spart_bus_arb (N=2) with an ack scoreboard and a
// pulled-up data bus so an undriven bus reads 0xFF.
module tb_spart_bus_arb;

   localparam int N = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N-1:0]     rw;
   logic [2*N-1:0]   addr;
   logic [8*N-1:0]   wdata;
   logic [N-1:0]     ack;
   logic [7:0]       rdata;
   logic [0:0]       grant_id;
   logic             iocs;
   logic             iorw;
   logic [1:0]       ioaddr;
   tri1  [7:0]       databus;
   logic             rda;
   logic             tbr;
   logic [7:0]       spart_rdata;
   logic [N-1:0]     ack_prev;

   typedef struct packed {
      logic [0:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   spart_bus_arb #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .rw       (rw),
      .addr     (addr),
      .wdata    (wdata),
      .ack      (ack),
      .rdata    (rdata),
      .grant_id (grant_id),
      .iocs     (iocs),
      .iorw     (iorw),
      .ioaddr   (ioaddr),
      .databus  (databus),
      .rda      (rda),
      .tbr      (tbr)
   );

   // SPART side: returns read data only while a read cycle is on the bus.
   assign databus = (iocs && iorw) ? spart_rdata : 8'hzz;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = 1'(id);
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_req(input int i, input logic rd, input logic [1:0] a, input logic [7:0] d);
      req[i]          = 1'b1;
      rw[i]           = rd;
      addr[2*i +: 2]  = a;
      wdata[8*i +: 8] = d;
   endtask

   // One clock: scoreboard any ack at the falling edge, then mimic the
   // requester dropping req at the edge that ends its ack cycle.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (ack !== '0) begin
         if (sb.size() == 0) begin
            chk("ack_unexpected", 32'(ack), 32'h0);
         end else begin
            e = sb.pop_front();
            chk("ack_vec", 32'(ack), 32'h1 << e.id);
            chk("ack_grant", 32'(grant_id), 32'(e.id));
            chk("ack_rdata", 32'(rdata), 32'(e.data));
         end
      end
      ack_prev = ack;
      @(posedge clk);
      #1;
      req = req & ~ack_prev;
   endtask

   initial begin
      rst = 1'b1; req = '0; rw = '0; addr = '0; wdata = '0;
      rda = 1'b0; tbr = 1'b1; spart_rdata = 8'h00; ack_prev = '0;
      tick();
      tick();
      chk("rst_iocs", 32'(iocs), 32'h0);
      chk("rst_iorw", 32'(iorw), 32'h0);
      chk("rst_ioaddr", 32'(ioaddr), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_grant", 32'(grant_id), 32'h0);
      chk("rst_bus", 32'(databus), 32'hFF);
      rst = 1'b0;
      tick();

      // Single write to divisor high byte; wdata change during ACCESS ignored.
      set_req(0, 1'b0, 2'b11, 8'h27);
      push(0, 8'h00);
      tick();
      chk("wr_iocs", 32'(iocs), 32'h1);
      chk("wr_iorw", 32'(iorw), 32'h0);
      chk("wr_ioaddr", 32'(ioaddr), 32'h3);
      chk("wr_bus", 32'(databus), 32'h27);
      chk("wr_grant", 32'(grant_id), 32'h0);
      wdata[7:0] = 8'h55;
      #1;
      chk("wr_bus_latched", 32'(databus), 32'h27);
      tick();
      chk("wr_ack", 32'(ack), 32'h1);
      chk("wr_ack_iocs", 32'(iocs), 32'h0);
      chk("wr_ack_bus", 32'(databus), 32'hFF);
      tick();

      // TX write gated by tbr.
      tbr = 1'b0;
      set_req(1, 1'b0, 2'b00, 8'h41);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("tx_gated_iocs", 32'(iocs), 32'h0);
      end
      tbr = 1'b1;
      push(1, 8'h00);
      tick();
      chk("tx_iocs", 32'(iocs), 32'h1);
      chk("tx_bus", 32'(databus), 32'h41);
      chk("tx_grant", 32'(grant_id), 32'h1);
      tbr = 1'b0;
      tick();
      chk("tx_ack", 32'(ack), 32'h2);
      tick();
      tbr = 1'b1;

      // Blocked RX read on 0 must not hold off the status read on 1.
      rda = 1'b0;
      spart_rdata = 8'h03;
      set_req(0, 1'b1, 2'b00, 8'h00);
      set_req(1, 1'b1, 2'b01, 8'h00);
      push(1, 8'h03);
      tick();
      chk("hol_iocs", 32'(iocs), 32'h1);
      chk("hol_iorw", 32'(iorw), 32'h1);
      chk("hol_ioaddr", 32'(ioaddr), 32'h1);
      chk("hol_grant", 32'(grant_id), 32'h1);
      tick();
      chk("hol_ack", 32'(ack), 32'h2);
      chk("hol_rdata", 32'(rdata), 32'h03);
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hol_wait_iocs", 32'(iocs), 32'h0);
      end
      rda = 1'b1;
      spart_rdata = 8'h5A;
      push(0, 8'h5A);
      tick();
      chk("rx_iocs", 32'(iocs), 32'h1);
      chk("rx_ioaddr", 32'(ioaddr), 32'h0);
      chk("rx_grant", 32'(grant_id), 32'h0);
      rda = 1'b0;
      tick();
      chk("rx_rdata", 32'(rdata), 32'h5A);
      tick();

      // Both requesters stream status reads: grants alternate, ack every 3 cycles.
      spart_rdata = 8'h03;
      for (int g = 0; g < 6; g++) begin
         int id;
         id = (g % 2 == 0) ? 1 : 0;
         push(id, 8'h03);
         set_req(0, 1'b1, 2'b01, 8'h00);
         set_req(1, 1'b1, 2'b01, 8'h00);
         tick();
         chk("rr_iocs", 32'(iocs), 32'h1);
         chk("rr_grant", 32'(grant_id), 32'(id));
         tick();
         chk("rr_ack", 32'(ack), 32'h1 << id);
         tick();
      end
      req = '0;
      tick();

      // Reset in the middle of a write access.
      set_req(0, 1'b0, 2'b10, 8'h99);
      tick();
      chk("mid_iocs_before", 32'(iocs), 32'h1);
      chk("mid_bus_before", 32'(databus), 32'h99);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_iocs", 32'(iocs), 32'h0);
      chk("mid_bus", 32'(databus), 32'hFF);
      chk("mid_ack", 32'(ack), 32'h0);
      req = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("mid_grant", 32'(grant_id), 32'h0);
      chk("mid_rdata", 32'(rdata), 32'h0);
      tick();
      chk("post_ack", 32'(ack), 32'h0);
      chk("post_iocs", 32'(iocs), 32'h0);

      // Pointer back at 0: requester 0 wins first, then 1.
      set_req(0, 1'b1, 2'b01, 8'h00);
      set_req(1, 1'b1, 2'b01, 8'h00);
      push(0, 8'h03);
      push(1, 8'h03);
      tick();
      chk("ptr0_grant", 32'(grant_id), 32'h0);
      for (int c = 0; c < 5; c++) begin
         tick();
      end
      req = '0;
      tick();
      tick();
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
